// File: rtl/seg7_pkg.sv
// Shared types and constants for the three-digit multiplexed 7-segment driver.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/BCD input and segment/anode output bundle of the 7-segment scan driver.
interface seg7_scan_driver_if;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg_n;
    logic [2:0] an_n;
    logic       frame_done;

    modport master (
        output load, hundreds, tens, ones,
        input  seg_n, an_n, frame_done
    );

    modport slave (
        input  load, hundreds, tens, ones,
        output seg_n, an_n, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment glyph; 10..15 render as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_DASH;
        case (nibble_i)
            4'd0: seg_n_o = 7'b1000000;
            4'd1: seg_n_o = 7'b1111001;
            4'd2: seg_n_o = 7'b0100100;
            4'd3: seg_n_o = 7'b0110000;
            4'd4: seg_n_o = 7'b0011001;
            4'd5: seg_n_o = 7'b0010010;
            4'd6: seg_n_o = 7'b0000010;
            4'd7: seg_n_o = 7'b1111000;
            4'd8: seg_n_o = 7'b0000000;
            4'd9: seg_n_o = 7'b0010000;
            default: seg_n_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver with shadow/display double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_SHOWN = CW'(BLANK - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    slot_state_e   state_q, state_d;
    bcd3_t         shadow_q, shadow_d;
    bcd3_t         display_q, display_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [2:0]    an_n_q, an_n_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          commit;
    logic [3:0]    digit;
    logic [6:0]    glyph;
    logic [2:0]    an_sel;
    logic          lzb_blank;

    assign slot_end = (cnt_q == CNT_LAST);
    assign commit   = slot_end && (idx_q == DIG_HUND);

    // Slot counter and digit index
    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (idx_q > DIG_HUND) begin
            idx_d = DIG_ONES;
        end else if (slot_end) begin
            idx_d = (idx_q == DIG_HUND) ? DIG_ONES : idx_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_q == CNT_SHOWN) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end)           state_d = ST_BLANK;
            default:                          state_d = ST_BLANK;
        endcase
    end

    // Commit reads the shadow as it was before this edge, so a coincident load
    // lands in the following frame.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        display_d = display_q;
        if (commit && pending_q) begin
            display_d = shadow_q;
        end
        if (commit) begin
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = '{hund: bus.hundreds, tens: bus.tens, ones: bus.ones};
            pending_d = 1'b1;
        end
    end

    // Outputs are derived from next-state values so the registered outputs line
    // up with the slot counter they belong to.
    always_comb begin
        digit = display_d.ones;
        case (idx_d)
            DIG_TENS: digit = display_d.tens;
            DIG_HUND: digit = display_d.hund;
            default:  digit = display_d.ones;
        endcase
    end

    seg7_decode u_decode (
        .nibble_i (digit),
        .seg_n_o  (glyph)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_anode
        assign an_sel[gi] = (idx_d != 2'(gi));
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        lzb_blank = 1'b0;
        if (idx_d == DIG_HUND && display_d.hund == 4'd0) begin
            lzb_blank = 1'b1;
        end
        if (idx_d == DIG_TENS && display_d.hund == 4'd0 && display_d.tens == 4'd0) begin
            lzb_blank = 1'b1;
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        seg_n_d      = SEG_OFF;
        an_n_d       = 3'b111;
        frame_done_d = commit;
        if (state_d == ST_SHOW && !lzb_blank) begin
            seg_n_d = glyph;
            an_n_d  = an_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= DIG_ONES;
            state_q      <= ST_BLANK;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            seg_n_q      <= SEG_OFF;
            an_n_q       <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: expected frames are queued as loads are driven and checked
// cycle by cycle each time frame_done marks the start of a new frame.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 3 * DIV;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    frame_t exp_q[$];
    int     checks_cnt = 0;
    int     errors_cnt = 0;
    int     frame_no   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t mk(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        frame_t f;
        f.h = h;
        f.t = t;
        f.o = o;
        return f;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit lzb_blank(input int slot, input frame_t f);
        bit en;
`ifdef SEG7_LZB_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ((slot == 2 && f.h == 4'd0) ||
                      (slot == 1 && f.h == 4'd0 && f.t == 4'd0));
    endfunction

    task automatic drive_load(input frame_t f);
        bus.load     = 1'b1;
        bus.hundreds = f.h;
        bus.tens     = f.t;
        bus.ones     = f.o;
    endtask

    // Advances until frame_done is seen; exp_n >= 0 also checks how many cycles that took.
    task automatic wait_frame(input int exp_n);
        int n = 0;
        while (bus.frame_done !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            bus.load = 1'b0;
            n++;
        end
        check("frame_done_seen", bus.frame_done, 1);
        if (exp_n >= 0) check("frame_latency", n, exp_n);
    endtask

    // Checks one whole frame starting at its frame_done cycle; optional loads at cycles la1/la2.
    task automatic check_frame(input int la1, input frame_t f1, input int la2, input frame_t f2);
        frame_t     e;
        logic [2:0] an_e;
        logic [6:0] seg_e;
        int         s, k;
        check("sb_nonempty", exp_q.size() != 0, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int c = 0; c < FRAME; c++) begin
            s = c / DIV;
            k = c % DIV;
            an_e  = 3'b111;
            seg_e = 7'h7F;
            if (k >= BLANK && !lzb_blank(s, e)) begin
                an_e  = ~(3'b001 << s);
                seg_e = glyph(s == 0 ? e.o : (s == 1 ? e.t : e.h));
            end
            check($sformatf("seg_n f%0d c%0d", frame_no, c), bus.seg_n, seg_e);
            check($sformatf("an_n f%0d c%0d", frame_no, c), bus.an_n, an_e);
            check($sformatf("frame_done f%0d c%0d", frame_no, c), bus.frame_done, (c == 0));
            if (c == la1) begin
                drive_load(f1);
                exp_q.push_back(f1);
            end else if (c == la2) begin
                drive_load(f2);
                exp_q.push_back(f2);
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        $display("frame %0d h=%0h t=%0h o=%0h checked", frame_no, e.h, e.t, e.o);
        frame_no++;
    endtask

    initial begin
        frame_t none;
        none = '0;
        bus.load     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;

        #1 rst_n = 1'b0;
        #1;
        check("reset seg_n", bus.seg_n, 7'h7F);
        check("reset an_n", bus.an_n, 3'b111);
        check("reset frame_done", bus.frame_done, 0);

        // Basic scan: 2,5,5 loaded right at reset release
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_load(mk(4'd2, 4'd5, 4'd5));
        exp_q.push_back(mk(4'd2, 4'd5, 4'd5));
        wait_frame(FRAME);
        exp_q.push_back(mk(4'd2, 4'd5, 4'd5));
        check_frame(-1, none, -1, none);

        // Tear-free: load 1,2,3 during the tens slot; old value holds this frame
        wait_frame(0);
        check_frame(10, mk(4'd1, 4'd2, 4'd3), -1, none);

        // Load B mid-frame, then A on the commit edge: B next frame, A the one after
        wait_frame(0);
        check_frame(10, mk(4'd4, 4'd0, 4'd9), FRAME - 1, mk(4'd3, 4'hC, 4'd8));
        wait_frame(0);
        check_frame(-1, none, -1, none);

        // Invalid BCD frame, then leading-zero cases
        wait_frame(0);
        check_frame(5, mk(4'd0, 4'd0, 4'd7), -1, none);
        wait_frame(0);
        check_frame(5, mk(4'd0, 4'd0, 4'd0), -1, none);
        wait_frame(0);
        check_frame(-1, none, -1, none);

        // Asynchronous reset in the middle of a SHOW interval discards pending data
        wait_frame(0);
        drive_load(mk(4'd9, 4'd9, 4'd9));
        @(negedge clk);
        bus.load = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset an_n lit", bus.an_n, 3'b101);
        #2 rst_n = 1'b0;
        #1;
        check("async reset seg_n", bus.seg_n, 7'h7F);
        check("async reset an_n", bus.an_n, 3'b111);
        check("async reset frame_done", bus.frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(4'd0, 4'd0, 4'd0));
        wait_frame(FRAME);
        check_frame(-1, none, -1, none);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
